// File: rtl/acl_spi_responder.sv
// SPI mode-0 responder modelling the 3-axis accelerometer register interface.
// Serves 0x0A writes / 0x0B reads against a 64-byte map and drives INT1/INT2.
module acl_spi_responder #(
   parameter logic [7:0] DEVID_AD  = 8'hAD,
   parameter logic [7:0] DEVID_MST = 8'h1D,
   parameter logic [7:0] PARTID    = 8'hF2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       CSN,
   input  logic       SCLK,
   input  logic       MOSI,
   output logic       MISO,
   input  logic [7:0] sample_x,
   input  logic [7:0] sample_y,
   input  logic [7:0] sample_z,
   input  logic       sample_load,
   output logic       INT1,
   output logic       INT2,
   output logic       wr_strobe,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [7:0] power_ctl
);

   typedef enum logic [2:0] {IDLE, INST, ADDR, DATA, IGNORE} state_t;

   state_t state_q, state_d;

   // CSN sync resets low so a reset inside a transaction never fakes a falling edge
   logic [2:0] csn_q, sclk_q;
   logic [1:0] mosi_q;
   logic       csn_fall, csn_rise, sclk_rise, sclk_fall;

   logic [2:0]        bit_cnt;
   logic [6:0]        shift_in;
   logic [7:0]        byte_in;
   logic              shift_en, byte_done;
   logic              is_read, load_next;
   logic [5:0]        addr;
   logic [7:0]        tx_sh;
   logic [7:0]        rd_byte;
   logic [14:0][7:0]  regs;
   logic [7:0]        x_q, y_q, z_q;
   logic              dr, dr_clr, srst_pend, wr_ok;

   assign csn_fall  = csn_q[2] & ~csn_q[1];
   assign csn_rise  = ~csn_q[2] & csn_q[1];
   assign sclk_rise = ~sclk_q[2] & sclk_q[1];
   assign sclk_fall = sclk_q[2] & ~sclk_q[1];
   assign byte_in   = {shift_in, mosi_q[1]};
   assign shift_en  = sclk_rise &
                      (state_q == INST || state_q == ADDR || state_q == DATA);
   assign byte_done = shift_en & (bit_cnt == 3'd7);
   assign wr_ok     = (addr >= 6'h20) && (addr <= 6'h2E);
   assign dr_clr    = sclk_fall & (state_q == DATA) & is_read & load_next &
                      (addr >= 6'h08) && (addr <= 6'h0A);
   assign MISO      = tx_sh[7];
   assign power_ctl = regs[13];

   always_comb begin
      rd_byte = 8'h00;
      if (wr_ok) begin
         rd_byte = regs[addr[3:0]];
      end else begin
         case (addr)
            6'h00:   rd_byte = DEVID_AD;
            6'h01:   rd_byte = DEVID_MST;
            6'h02:   rd_byte = PARTID;
            6'h03:   rd_byte = 8'h01;
            6'h08:   rd_byte = x_q;
            6'h09:   rd_byte = y_q;
            6'h0A:   rd_byte = z_q;
            6'h0B:   rd_byte = {7'd0, dr};
            default: rd_byte = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (csn_rise) begin
         state_d = IDLE;
      end else if (csn_fall) begin
         state_d = INST;
      end else if (byte_done) begin
         case (state_q)
            INST: state_d = (byte_in == 8'h0A || byte_in == 8'h0B) ? ADDR : IGNORE;
            ADDR: state_d = DATA;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csn_q     <= 3'b000;
         sclk_q    <= 3'b000;
         mosi_q    <= 2'b00;
         bit_cnt   <= 3'd0;
         shift_in  <= 7'd0;
         is_read   <= 1'b0;
         load_next <= 1'b0;
         addr      <= 6'd0;
         tx_sh     <= 8'd0;
         regs      <= '0;
         x_q       <= 8'd0;
         y_q       <= 8'd0;
         z_q       <= 8'd0;
         dr        <= 1'b0;
         srst_pend <= 1'b0;
         INT1      <= 1'b0;
         INT2      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= 8'd0;
         wr_data   <= 8'd0;
      end else begin
         csn_q     <= {csn_q[1:0], CSN};
         sclk_q    <= {sclk_q[1:0], SCLK};
         mosi_q    <= {mosi_q[0], MOSI};
         wr_strobe <= 1'b0;
         srst_pend <= 1'b0;
         INT1      <= (dr & regs[10][0]) ^ regs[7][1];
         INT2      <= (dr & regs[11][0]) ^ regs[7][1];

         if (sample_load) begin
            x_q <= sample_x;
            y_q <= sample_y;
            z_q <= sample_z;
         end
         if (sample_load)             dr <= 1'b1;
         else if (dr_clr | srst_pend) dr <= 1'b0;
         if (srst_pend) regs <= '0;

         if (csn_fall | csn_rise) begin
            bit_cnt   <= 3'd0;
            tx_sh     <= 8'd0;
            load_next <= 1'b0;
         end else begin
            if (shift_en) begin
               shift_in <= byte_in[6:0];
               bit_cnt  <= bit_cnt + 3'd1;
            end
            if (byte_done) begin
               case (state_q)
                  INST: is_read <= (byte_in == 8'h0B);
                  ADDR: begin
                     addr      <= byte_in[5:0];
                     load_next <= is_read;
                  end
                  DATA: begin
                     addr      <= addr + 6'd1;
                     load_next <= is_read;
                     if (!is_read && wr_ok) begin
                        regs[addr[3:0]] <= byte_in;
                        wr_strobe       <= 1'b1;
                        wr_addr         <= {2'b00, addr};
                        wr_data         <= byte_in;
                     end
                     if (!is_read && addr == 6'h1F && byte_in == 8'h52)
                        srst_pend <= 1'b1;
                  end
                  default: ;
               endcase
            end
            // a new byte is fetched on the first fall after each completed byte
            if (sclk_fall && state_q == DATA && is_read) begin
               if (load_next) begin
                  tx_sh     <= rd_byte;
                  load_next <= 1'b0;
               end else begin
                  tx_sh <= {tx_sh[6:0], 1'b0};
               end
            end
         end
      end
   end

endmodule

// File: doc/acl_spi_responder.md
Name: acl_spi_responder

Overview:
- SPI slave model of the 3-axis accelerometer; the responder end of the accelerometer SPI link.
- Decodes write-register (0x0A) and read-register (0x0B) transactions and serves reads from an internal 64-byte register map.
- Loads sample registers from parallel inputs and drives INT1/INT2.
- Used as the on-chip/bench counterpart when testing the SPI master controller without the physical sensor.

Parameters:
- DEVID_AD, 8'hAD, read-only value at address 0x00
- DEVID_MST, 8'h1D, read-only value at address 0x01
- PARTID, 8'hF2, read-only value at address 0x02

Ports:
- clk  in  1  system clock; must run at ≥4× SCLK
- rst  in  1  asynchronous, active-high reset
- CSN  in  1  SPI chip select, active low
- SCLK  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- MOSI  in  1  SPI data from master
- MISO  out  1  SPI data to master
- sample_x  in  8  X sample
- sample_y  in  8  Y sample
- sample_z  in  8  Z sample
- sample_load  in  1  one-cycle strobe: capture samples
- INT1  out  1  interrupt 1
- INT2  out  1  interrupt 2
- wr_strobe  out  1  one-cycle pulse per accepted register write
- wr_addr  out  8  address of accepted write
- wr_data  out  8  data of accepted write
- power_ctl  out  8  current value of register 0x2D

Behaviour:
- Input sync: CSN, SCLK and MOSI each pass through a 2-flop synchronizer on clk. SCLK rise/fall and CSN fall/rise are detected on the synchronized signals; all logic is clocked by clk.
- Reset values: MISO=0, INT1=0, INT2=0, wr_strobe=0, wr_addr=0, wr_data=0, power_ctl=0. All writable registers are 0, samples are 0, DATA_READY is 0, and the FSM is in IDLE.
- Register map (address width 6 bits, addr[7:6] ignored):
  - 0x00 DEVID_AD, 0x01 DEVID_MST, 0x02 PARTID, 0x03 = 0x01. All read-only.
  - 0x08 X, 0x09 Y, 0x0A Z. Read-only.
  - 0x0B STATUS: bit0 = DATA_READY, other bits 0.
  - 0x1F SOFT_RESET: write-only, reads return 0.
  - 0x20–0x2E: read/write.
  - All other addresses read 0x00; writes to them are ignored (no wr_strobe).
- FSM states: IDLE, INST, ADDR, DATA, IGNORE.
  - CSN falling -> INST, bit counter = 0.
  - INST: shift MOSI MSB-first on each SCLK rise; after the 8th bit -> ADDR. An instruction other than 0x0A/0x0B -> IGNORE.
  - ADDR: after 8 bits, latch the address -> DATA.
  - DATA (write): each completed byte is written to reg[addr] if writable, pulsing wr_strobe/wr_addr/wr_data for one clk. Address then increments.
  - DATA (read): on the SCLK fall following the last address bit, load reg[addr] into the TX shift register and drive bit7 on MISO. Subsequent SCLK falls shift out the following bits. On completion of each byte, increment the address and load the next byte at the next fall.
  - IGNORE: consume clocks, MISO=0 until CSN rises.
  - CSN rising in any state -> IDLE, MISO=0. A partial byte is discarded: no write, no strobe.
- Address auto-increment wraps 0x3F -> 0x00.
- Writing 0x52 to 0x1F clears 0x20–0x2E and DATA_READY one clk after the byte completes; no wr_strobe. Any other value written to 0x1F is ignored.
- sample_load: X/Y/Z registers update on the next clk edge and DATA_READY is set. A byte already loaded into the TX shift register is unaffected.
- DATA_READY clear: cleared when a byte from 0x08, 0x09 or 0x0A is loaded for read. If sample_load coincides with the clear, set wins.
- Interrupts:
  - INT1 = DATA_READY & reg[0x2A][0].
  - INT2 = DATA_READY & reg[0x2B][0].
  - If reg[0x27][1] = 1, both interrupts are inverted (active low).
  - Both interrupts are registered, with 1 clk latency.
- power_ctl mirrors reg[0x2D], updating with the write.
- rst mid-transaction: everything returns to reset values immediately. The remainder of the transaction is treated as IGNORE until the next CSN falling edge.

Test Plan:
- Read 0x0B, 0x00 (3-byte transaction) -> MISO returns 0xAD. Continuing the burst returns 0x1D, then 0xF2.
- Write 0x0A, 0x2D, 0x0A -> wr_strobe pulses once with wr_addr=0x2D, wr_data=0x0A. power_ctl=0x0A. A subsequent read of 0x2D returns 0x0A.
- Write 0x0A, 0x2A, 0x01, then sample_load with x=0x11, y=0x22, z=0x33 -> INT1=1. Burst read from 0x08 returns 0x11, 0x22, 0x33. INT1=0 after the first byte load.
- Burst read starting at 0x3F for 2 bytes -> returns 0x00 then 0xAD (wrap). Writes to 0x00 and 0x10 -> no wr_strobe, values unchanged.
- CSN raised after 4 bits of a write data byte to 0x20 -> no wr_strobe, reg 0x20 unchanged. Instruction 0x55 -> MISO held 0 for the whole transaction.
- Write 0x52 to 0x1F after configuring 0x20–0x2D -> all read back 0x00, INT1/INT2=0. Asserting rst mid-read -> MISO=0 and the FSM is in IDLE.
